// File: rtl/arp_reply_gen_pkg.sv
// Shared ARP/Ethernet constants, FSM encoding and the parallel frame record
// used by the ARP reply generator.
package arp_pkg;

  localparam logic [15:0] ETH_TYPE_ARP     = 16'h0806;
  localparam logic [15:0] ARP_HTYPE_ETH    = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4   = 16'h0800;
  localparam logic [7:0]  ARP_HLEN_ETH     = 8'd6;
  localparam logic [7:0]  ARP_PLEN_IPV4    = 8'd4;
  localparam logic [15:0] ARP_OPER_REQUEST = 16'h0001;
  localparam logic [15:0] ARP_OPER_REPLY   = 16'h0002;
  localparam logic [47:0] ETH_BCAST_MAC    = 48'hffff_ffff_ffff;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } arp_state_e;

  typedef struct packed {
    logic [47:0] eth_dest_mac;
    logic [47:0] eth_src_mac;
    logic [15:0] eth_type;
    logic [15:0] arp_htype;
    logic [15:0] arp_ptype;
    logic [15:0] arp_oper;
    logic [7:0]  arp_hlen;
    logic [7:0]  arp_plen;
    logic [47:0] arp_sha;
    logic [31:0] arp_spa;
    logic [47:0] arp_tha;
    logic [31:0] arp_tpa;
  } arp_frame_t;

endpackage

// File: rtl/arp_reply_gen_if.sv
// Parsed ARP frame handshake: valid/ready plus the frame as parallel fields.
interface arp_frame_if;

  logic        valid;
  logic        ready;
  logic [47:0] eth_dest_mac;
  logic [47:0] eth_src_mac;
  logic [15:0] eth_type;
  logic [15:0] arp_htype;
  logic [15:0] arp_ptype;
  logic [15:0] arp_oper;
  logic [7:0]  arp_hlen;
  logic [7:0]  arp_plen;
  logic [47:0] arp_sha;
  logic [47:0] arp_tha;
  logic [31:0] arp_spa;
  logic [31:0] arp_tpa;

  modport master (
    output valid, eth_dest_mac, eth_src_mac, eth_type, arp_htype, arp_ptype,
           arp_oper, arp_hlen, arp_plen, arp_sha, arp_tha, arp_spa, arp_tpa,
    input  ready
  );

  modport slave (
    input  valid, eth_dest_mac, eth_src_mac, eth_type, arp_htype, arp_ptype,
           arp_oper, arp_hlen, arp_plen, arp_sha, arp_tha, arp_spa, arp_tpa,
    output ready
  );

endinterface

// File: rtl/arp_reply_gen_match.sv
// Combinational predicate: is this frame an ARP request for our IP that we
// should answer (conflicting sender addresses are never answered).
module arp_req_match
  import arp_pkg::*;
(
  input  logic [47:0] eth_dest_mac,
  input  logic [15:0] eth_type,
  input  logic [15:0] arp_htype,
  input  logic [15:0] arp_ptype,
  input  logic [15:0] arp_oper,
  input  logic [7:0]  arp_hlen,
  input  logic [7:0]  arp_plen,
  input  logic [31:0] arp_spa,
  input  logic [31:0] arp_tpa,
  input  logic [47:0] local_mac,
  input  logic [31:0] local_ip,
  output logic        match
);

  logic hdr_ok_s;
  logic dest_ok_s;
  logic ip_ok_s;

  // Header, destination and address qualification of the candidate request.
  always_comb begin
    hdr_ok_s  = (eth_type == ETH_TYPE_ARP) && (arp_htype == ARP_HTYPE_ETH) &&
                (arp_ptype == ARP_PTYPE_IPV4) && (arp_hlen == ARP_HLEN_ETH) &&
                (arp_plen == ARP_PLEN_IPV4) && (arp_oper == ARP_OPER_REQUEST);
    dest_ok_s = (eth_dest_mac == ETH_BCAST_MAC) || (eth_dest_mac == local_mac);
    ip_ok_s   = (arp_tpa == local_ip) && (arp_spa != local_ip);
    match     = hdr_ok_s && dest_ok_s && ip_ok_s;
  end

endmodule

// File: rtl/arp_reply_gen.sv
// ARP reply generator: answers ARP requests for local_ip through one output
// register. Optional duplicate hold-off is built with ARP_REPLY_HOLDOFF_EN.
module arp_reply_gen
  import arp_pkg::*;
#(
  parameter int CNT_WIDTH      = 16,
  parameter int HOLDOFF_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  arp_frame_if.slave           s_frame,
  arp_frame_if.master          m_frame,
  input  logic [47:0]          local_mac,
  input  logic [31:0]          local_ip,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] reply_count,
  output logic [CNT_WIDTH-1:0] drop_count
);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_SEND = SEND;

  logic [0:0]           state_r;
  logic                 ready_r;
  arp_frame_t           reply_r;
  arp_frame_t           reply_s;
  logic [CNT_WIDTH-1:0] reply_count_r;
  logic [CNT_WIDTH-1:0] drop_count_r;
  logic                 accept_s;
  logic                 match_s;
  logic                 dup_s;
  logic                 reply_go_s;
  logic                 drop_go_s;
  logic                 unused_s;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_WIDTH'(1);
    end
  endfunction

  arp_req_match u_match (
    .eth_dest_mac (s_frame.eth_dest_mac),
    .eth_type     (s_frame.eth_type),
    .arp_htype    (s_frame.arp_htype),
    .arp_ptype    (s_frame.arp_ptype),
    .arp_oper     (s_frame.arp_oper),
    .arp_hlen     (s_frame.arp_hlen),
    .arp_plen     (s_frame.arp_plen),
    .arp_spa      (s_frame.arp_spa),
    .arp_tpa      (s_frame.arp_tpa),
    .local_mac    (local_mac),
    .local_ip     (local_ip),
    .match        (match_s)
  );

  // ready_r is only ever high in IDLE, so it alone qualifies an accept.
  assign accept_s   = s_frame.valid && ready_r;
  assign reply_go_s = accept_s && match_s && !dup_s;
  assign drop_go_s  = accept_s && !reply_go_s;

`ifdef ARP_REPLY_HOLDOFF_EN
  localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  logic              rec_valid_r;
  logic [31:0]       rec_spa_r;
  logic [47:0]       rec_sha_r;
  logic [HOLD_W-1:0] hold_cnt_r;

  // A request repeating the last answered sender inside the window is a duplicate.
  always_comb begin
    dup_s = rec_valid_r && (hold_cnt_r != {HOLD_W{1'b0}}) &&
            (s_frame.arp_spa == rec_spa_r) && (s_frame.arp_sha == rec_sha_r);
  end

  // Last-reply record and its hold-off down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_valid_r <= 1'b0;
      rec_spa_r   <= 32'h0;
      rec_sha_r   <= 48'h0;
      hold_cnt_r  <= {HOLD_W{1'b0}};
    end else if (reply_go_s) begin
      rec_valid_r <= 1'b1;
      rec_spa_r   <= s_frame.arp_spa;
      rec_sha_r   <= s_frame.arp_sha;
      hold_cnt_r  <= HOLD_W'(HOLDOFF_CYCLES - 1);
    end else if (hold_cnt_r != {HOLD_W{1'b0}}) begin
      hold_cnt_r <= hold_cnt_r - HOLD_W'(1);
      if (hold_cnt_r == HOLD_W'(1)) begin
        rec_valid_r <= 1'b0;
      end
    end else begin
      rec_valid_r <= 1'b0;
    end
  end
`else
  // Without hold-off every matching request is answered.
  always_comb begin
    dup_s = 1'b0;
  end
`endif

  // Reply fields are captured from the request and the station identity at accept.
  always_comb begin
    reply_s              = '0;
    reply_s.eth_dest_mac = s_frame.arp_sha;
    reply_s.eth_src_mac  = local_mac;
    reply_s.eth_type     = ETH_TYPE_ARP;
    reply_s.arp_htype    = ARP_HTYPE_ETH;
    reply_s.arp_ptype    = ARP_PTYPE_IPV4;
    reply_s.arp_hlen     = ARP_HLEN_ETH;
    reply_s.arp_plen     = ARP_PLEN_IPV4;
    reply_s.arp_oper     = ARP_OPER_REPLY;
    reply_s.arp_sha      = local_mac;
    reply_s.arp_spa      = local_ip;
    reply_s.arp_tha      = s_frame.arp_sha;
    reply_s.arp_tpa      = s_frame.arp_spa;
  end

  // Control FSM and output register; no bypass, so SEND always drains before IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b0;
      reply_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (reply_go_s) begin
            state_r <= ST_SEND;
            ready_r <= 1'b0;
            reply_r <= reply_s;
          end else begin
            ready_r <= 1'b1;
          end
        end
        ST_SEND: begin
          if (m_frame.ready) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
          end else begin
            ready_r <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Saturating status counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reply_count_r <= {CNT_WIDTH{1'b0}};
      drop_count_r  <= {CNT_WIDTH{1'b0}};
    end else begin
      if (reply_go_s) begin
        reply_count_r <= sat_inc(reply_count_r);
      end
      if (drop_go_s) begin
        drop_count_r <= sat_inc(drop_count_r);
      end
    end
  end

  assign s_frame.ready        = ready_r;
  assign m_frame.valid        = (state_r == ST_SEND);
  assign busy                 = (state_r == ST_SEND);
  assign reply_count          = reply_count_r;
  assign drop_count           = drop_count_r;
  assign m_frame.eth_dest_mac = reply_r.eth_dest_mac;
  assign m_frame.eth_src_mac  = reply_r.eth_src_mac;
  assign m_frame.eth_type     = reply_r.eth_type;
  assign m_frame.arp_htype    = reply_r.arp_htype;
  assign m_frame.arp_ptype    = reply_r.arp_ptype;
  assign m_frame.arp_oper     = reply_r.arp_oper;
  assign m_frame.arp_hlen     = reply_r.arp_hlen;
  assign m_frame.arp_plen     = reply_r.arp_plen;
  assign m_frame.arp_sha      = reply_r.arp_sha;
  assign m_frame.arp_spa      = reply_r.arp_spa;
  assign m_frame.arp_tha      = reply_r.arp_tha;
  assign m_frame.arp_tpa      = reply_r.arp_tpa;

  assign unused_s = ^{s_frame.eth_src_mac, s_frame.arp_tha, 32'(HOLDOFF_CYCLES)};

endmodule

// File: tb/tb_arp_reply_gen.sv
// Self-checking bench for arp_reply_gen: directed cases plus randomized traffic
// compared every cycle against a transaction-level reply model.
module tb_arp_reply_gen;
  import arp_pkg::*;

  localparam int CW   = 4;
  localparam int HOLD = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [47:0]   lmac = 48'h02_00_00_00_00_01;
  logic [31:0]   lip  = 32'hc0a8_010a;
  logic          busy;
  logic [CW-1:0] rc;
  logic [CW-1:0] dc;
  int            n_chk = 0;
  int            n_fail = 0;

  arp_frame_if s_if ();
  arp_frame_if m_if ();

  arp_reply_gen #(.CNT_WIDTH(CW), .HOLDOFF_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .s_frame(s_if), .m_frame(m_if),
    .local_mac(lmac), .local_ip(lip), .busy(busy),
    .reply_count(rc), .drop_count(dc)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_frame(input string nm, input arp_frame_t act, input arp_frame_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic arp_frame_t mk_req(logic [47:0] dst, logic [47:0] sha,
                                        logic [31:0] spa, logic [31:0] tpa);
    arp_frame_t f;
    f.eth_dest_mac = dst;       f.eth_src_mac = sha;
    f.eth_type = 16'h0806;      f.arp_htype = 16'h0001; f.arp_ptype = 16'h0800;
    f.arp_oper = 16'h0001;      f.arp_hlen = 8'd6;      f.arp_plen = 8'd4;
    f.arp_sha = sha;            f.arp_spa = spa;
    f.arp_tha = 48'h0;          f.arp_tpa = tpa;
    return f;
  endfunction

  function automatic bit wants_reply(arp_frame_t f, logic [47:0] mac, logic [31:0] ip);
    return f.eth_type == 16'h0806 && f.arp_htype == 16'h0001 && f.arp_ptype == 16'h0800 &&
           f.arp_hlen == 8'd6 && f.arp_plen == 8'd4 && f.arp_oper == 16'h0001 &&
           f.arp_tpa == ip && f.arp_spa != ip &&
           (f.eth_dest_mac == 48'hffff_ffff_ffff || f.eth_dest_mac == mac);
  endfunction

  function automatic arp_frame_t reply_of(arp_frame_t f, logic [47:0] mac, logic [31:0] ip);
    arp_frame_t r;
    r.eth_dest_mac = f.arp_sha; r.eth_src_mac = mac;    r.eth_type = 16'h0806;
    r.arp_htype = 16'h0001;     r.arp_ptype = 16'h0800; r.arp_oper = 16'h0002;
    r.arp_hlen = 8'd6;          r.arp_plen = 8'd4;
    r.arp_sha = mac;            r.arp_spa = ip;
    r.arp_tha = f.arp_sha;      r.arp_tpa = f.arp_spa;
    return r;
  endfunction

  function automatic logic [CW-1:0] sat(logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic arp_frame_t cur_in();
    arp_frame_t f;
    f.eth_dest_mac = s_if.eth_dest_mac; f.eth_src_mac = s_if.eth_src_mac;
    f.eth_type = s_if.eth_type;   f.arp_htype = s_if.arp_htype; f.arp_ptype = s_if.arp_ptype;
    f.arp_oper = s_if.arp_oper;   f.arp_hlen = s_if.arp_hlen;   f.arp_plen = s_if.arp_plen;
    f.arp_sha = s_if.arp_sha;     f.arp_spa = s_if.arp_spa;
    f.arp_tha = s_if.arp_tha;     f.arp_tpa = s_if.arp_tpa;
    return f;
  endfunction

  function automatic arp_frame_t cur_out();
    arp_frame_t f;
    f.eth_dest_mac = m_if.eth_dest_mac; f.eth_src_mac = m_if.eth_src_mac;
    f.eth_type = m_if.eth_type;   f.arp_htype = m_if.arp_htype; f.arp_ptype = m_if.arp_ptype;
    f.arp_oper = m_if.arp_oper;   f.arp_hlen = m_if.arp_hlen;   f.arp_plen = m_if.arp_plen;
    f.arp_sha = m_if.arp_sha;     f.arp_spa = m_if.arp_spa;
    f.arp_tha = m_if.arp_tha;     f.arp_tpa = m_if.arp_tpa;
    return f;
  endfunction

  bit            exp_ready = 1'b0;
  bit            exp_busy  = 1'b0;
  logic [CW-1:0] exp_rc    = '0;
  logic [CW-1:0] exp_dc    = '0;
  arp_frame_t    exp_reply = '0;
`ifdef ARP_REPLY_HOLDOFF_EN
  int unsigned   cyc = 0;
  int unsigned   rec_cyc = 0;
  bit            rec_v = 1'b0;
  logic [31:0]   rec_spa = '0;
  logic [47:0]   rec_sha = '0;
`endif

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_ready = 1'b0; exp_busy = 1'b0; exp_rc = '0; exp_dc = '0;
`ifdef ARP_REPLY_HOLDOFF_EN
        rec_v = 1'b0;
`endif
      end else begin
        arp_frame_t f;
        bit acc;
        bit dup;
        f = cur_in();
        if (exp_busy) begin
          if (m_if.ready) begin
            exp_busy = 1'b0; exp_ready = 1'b1;
          end
        end else begin
          acc = exp_ready && s_if.valid;
          exp_ready = 1'b1;
          if (acc) begin
            dup = 1'b0;
`ifdef ARP_REPLY_HOLDOFF_EN
            dup = rec_v && f.arp_spa == rec_spa && f.arp_sha == rec_sha &&
                  (cyc - rec_cyc) < HOLD;
`endif
            if (wants_reply(f, lmac, lip) && !dup) begin
              exp_busy = 1'b1; exp_ready = 1'b0;
              exp_reply = reply_of(f, lmac, lip);
              exp_rc = sat(exp_rc);
`ifdef ARP_REPLY_HOLDOFF_EN
              rec_v = 1'b1; rec_spa = f.arp_spa; rec_sha = f.arp_sha; rec_cyc = cyc;
`endif
            end else begin
              exp_dc = sat(exp_dc);
            end
          end
        end
`ifdef ARP_REPLY_HOLDOFF_EN
        cyc++;
`endif
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("s_ready", 64'(s_if.ready), 64'(exp_ready));
    check("m_valid", 64'(m_if.valid), 64'(exp_busy));
    check("busy", 64'(busy), 64'(exp_busy));
    check("reply_count", 64'(rc), 64'(exp_rc));
    check("drop_count", 64'(dc), 64'(exp_dc));
    if (exp_busy) check_frame("reply_frame", cur_out(), exp_reply);
  end

  // ---------------- stimulus ----------------
  task automatic drive(input arp_frame_t f);
    s_if.eth_dest_mac = f.eth_dest_mac; s_if.eth_src_mac = f.eth_src_mac;
    s_if.eth_type = f.eth_type;   s_if.arp_htype = f.arp_htype; s_if.arp_ptype = f.arp_ptype;
    s_if.arp_oper = f.arp_oper;   s_if.arp_hlen = f.arp_hlen;   s_if.arp_plen = f.arp_plen;
    s_if.arp_sha = f.arp_sha;     s_if.arp_spa = f.arp_spa;
    s_if.arp_tha = f.arp_tha;     s_if.arp_tpa = f.arp_tpa;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present a frame until accepted; returns #1 after the accepting edge.
  task automatic send(input arp_frame_t f);
    bit r;
    bit ok;
    drive(f);
    s_if.valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      r = s_if.ready;
      @(posedge clk);
      #1;
      ok = r;
    end
    s_if.valid = 1'b0;
    if (!ok) check("accept_timeout", 64'(ok), 64'(1));
  endtask

  function automatic arp_frame_t gen();
    arp_frame_t  f;
    logic [63:0] rnd;
    logic [47:0] dst;
    logic [47:0] sha;
    logic [31:0] spa;
    rnd = {$urandom(), $urandom()};
    sha = ($urandom_range(0, 1) == 0) ? 48'h5a5a_0000_0001 : 48'h5a5a_0000_0002;
    case ($urandom_range(0, 7))
      0:       spa = lip;
      1, 2, 3: spa = 32'h0a00_0001;
      default: spa = 32'h0a00_0002;
    endcase
    case ($urandom_range(0, 3))
      0, 1:    dst = 48'hffff_ffff_ffff;
      2:       dst = lmac;
      default: dst = rnd[47:0];
    endcase
    f = mk_req(dst, sha, spa, lip);
    case ($urandom_range(0, 15))
      0:       f.eth_type = 16'h0800;
      1:       f.arp_htype = 16'h0006;
      2:       f.arp_ptype = 16'h86dd;
      3:       f.arp_hlen = 8'd8;
      4:       f.arp_plen = 8'd16;
      5:       f.arp_oper = 16'h0002;
      6:       f.arp_tpa = lip ^ 32'h0000_0001;
      7:       f.arp_tpa = rnd[63:32];
      default: ;
    endcase
    return f;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    arp_frame_t req;
    arp_frame_t f;
    bit r_prev;
    s_if.valid = 1'b0;
    m_if.ready = 1'b1;
    drive('0);
    #12;
    check("rst_m_valid", 64'(m_if.valid), 64'(0));
    check("rst_s_ready", 64'(s_if.ready), 64'(0));
    check("rst_oper", 64'(m_if.arp_oper), 64'(0));
    #10 rst_n = 1'b1;
    idle(1);

    // 1: basic broadcast request
    req = mk_req(48'hffff_ffff_ffff, 48'haabb_ccdd_eeff, 32'hc0a8_0114, 32'hc0a8_010a);
    send(req);
    check("t1_valid", 64'(m_if.valid), 64'(1));
    check("t1_oper", 64'(m_if.arp_oper), 64'h2);
    check("t1_eth_dest", 64'(m_if.eth_dest_mac), 64'haabb_ccdd_eeff);
    check("t1_tha", 64'(m_if.arp_tha), 64'haabb_ccdd_eeff);
    check("t1_tpa", 64'(m_if.arp_tpa), 64'hc0a8_0114);
    check("t1_sha", 64'(m_if.arp_sha), 64'h0200_0000_0001);
    check("t1_spa", 64'(m_if.arp_spa), 64'hc0a8_010a);
    check("t1_reply_count", 64'(rc), 64'(1));
    idle(2);

    // 2: four kinds of non-matching frames, back to back
    f = req; f.arp_tpa = 32'hc0a8_010b; send(f);
    f = req; f.arp_oper = 16'h0002;     send(f);
    f = req; f.arp_ptype = 16'h86dd;    send(f);
    f = req; f.arp_hlen = 8'd8;         send(f);
    check("t2_drop_count", 64'(dc), 64'(4));
    check("t2_ready", 64'(s_if.ready), 64'(1));
    check("t2_no_valid", 64'(m_if.valid), 64'(0));

    // 3: backpressure with a second request waiting
    m_if.ready = 1'b0;
    send(mk_req(48'hffff_ffff_ffff, 48'h1111_1111_1111, 32'hc0a8_0115, 32'hc0a8_010a));
    drive(mk_req(48'h0200_0000_0001, 48'h2222_2222_2222, 32'hc0a8_0116, 32'hc0a8_010a));
    s_if.valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_ready_low", 64'(s_if.ready), 64'(0));
      check("t3_hold_tpa", 64'(m_if.arp_tpa), 64'hc0a8_0115);
    end
    @(posedge clk); #1;
    m_if.ready = 1'b1;
    send(mk_req(48'h0200_0000_0001, 48'h2222_2222_2222, 32'hc0a8_0116, 32'hc0a8_010a));
    check("t3_second_valid", 64'(m_if.valid), 64'(1));
    check("t3_second_tpa", 64'(m_if.arp_tpa), 64'hc0a8_0116);
    check("t3_reply_count", 64'(rc), 64'(3));
    idle(2);

    // 4: drop counter saturation
    f = req; f.arp_oper = 16'h0002;
    for (int i = 0; i < 20; i++) send(f);
    check("t4_drop_sat", 64'(dc), 64'(15));

`ifdef ARP_REPLY_HOLDOFF_EN
    // 5: duplicate suppression window
    f = mk_req(48'hffff_ffff_ffff, 48'h3333_3333_3333, 32'hc0a8_0132, 32'hc0a8_010a);
    send(f);
    check("t5_first", 64'(m_if.valid), 64'(1));
    idle(4);
    send(f);
    check("t5_dup_dropped", 64'(m_if.valid), 64'(0));
    idle(24);
    send(f);
    check("t5_after_window", 64'(m_if.valid), 64'(1));
    idle(1);
    f.arp_spa = 32'hc0a8_0133;
    send(f);
    check("t5_other_spa", 64'(m_if.valid), 64'(1));
    idle(2);
`endif

    // 6: asynchronous reset while a reply is pending
    m_if.ready = 1'b0;
    send(mk_req(48'hffff_ffff_ffff, 48'h4444_4444_4444, 32'hc0a8_0140, 32'hc0a8_010a));
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid", 64'(m_if.valid), 64'(0));
    check("t6_ready", 64'(s_if.ready), 64'(0));
    check("t6_busy", 64'(busy), 64'(0));
    check("t6_rc", 64'(rc), 64'(0));
    check("t6_dc", 64'(dc), 64'(0));
    check("t6_tpa", 64'(m_if.arp_tpa), 64'(0));
    @(negedge clk); #1 rst_n = 1'b1;
    m_if.ready = 1'b1;
    idle(3);
    check("t6_ready_back", 64'(s_if.ready), 64'(1));
    check("t6_no_stale", 64'(m_if.valid), 64'(0));

    // random traffic
    r_prev = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!(s_if.valid && !r_prev)) begin
        s_if.valid = ($urandom_range(0, 9) < 7);
        drive(gen());
      end
      m_if.ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 199) == 0) lip = {24'hc0a801, 8'($urandom_range(1, 3))};
      if ($urandom_range(0, 199) == 0) lmac = {40'h02_0000_0000, 8'($urandom_range(1, 2))};
      @(negedge clk);
      r_prev = s_if.ready;
      @(posedge clk);
      #1;
    end
    s_if.valid = 1'b0;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
